// File: rtl/pwm_multi_gen_if.sv
// Configuration write bus for pwm_multi_gen: one strobe, target channel and the shadow fields.
// cfg_dead only exists when PWM_DEADTIME_EN is defined.
interface pwm_multi_gen_if #(
   parameter int N_CH  = 2,
   parameter int CNT_W = 16,
   parameter int DT_W  = 8
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic             cfg_we;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_period;
   logic [CNT_W-1:0] cfg_high;
   logic [CNT_W-1:0] cfg_phase;
`ifdef PWM_DEADTIME_EN
   logic [DT_W-1:0]  cfg_dead;

   modport master (output cfg_we, cfg_ch, cfg_period, cfg_high, cfg_phase, cfg_dead);
   modport slave  (input  cfg_we, cfg_ch, cfg_period, cfg_high, cfg_phase, cfg_dead);
`else
   modport master (output cfg_we, cfg_ch, cfg_period, cfg_high, cfg_phase);
   modport slave  (input  cfg_we, cfg_ch, cfg_period, cfg_high, cfg_phase);
`endif
endinterface

// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: N_CH PWM channels with shadowed period/high/phase and complementary outputs.
// Define PWM_DEADTIME_EN to add per-channel dead-time insertion between out_p and out_n.
//
// state | meaning
// IDLE  | channel disabled: cnt and outputs held at 0, active config tracks pending
// RUN   | cnt runs 0..period-1, out_p follows cnt < high one cycle later
module pwm_multi_gen #(
   parameter int N_CH  = 2,
   parameter int CNT_W = 16,
   parameter int DT_W  = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] en,
   input  logic            sync,
   pwm_multi_gen_if.slave  cfg,
   output logic [N_CH-1:0] out_p,
   output logic [N_CH-1:0] out_n,
   output logic [N_CH-1:0] wrap
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      state_t           state, state_nxt;
      logic [CNT_W-1:0] pend_period, pend_high, pend_phase;
      logic [CNT_W-1:0] act_period, act_high;
      logic [CNT_W-1:0] cnt, cnt_nxt, start_cnt;
      logic             wr_hit, load, active, lvl;
      logic             p_nxt, n_nxt, wrap_nxt;
      logic             p_q, n_q, wrap_q;

      // Out-of-range channel numbers never match any i, so those writes drop silently.
      assign wr_hit    = cfg.cfg_we && (cfg.cfg_ch == CH_W'(i));
      assign start_cnt = (pend_phase < pend_period) ? pend_phase : '0;
      assign active    = (state == RUN) && en[i] && (act_period != '0);
      assign lvl       = active && (cnt < act_high);

      always_ff @(posedge clk) begin
         if (rst) state <= IDLE;
         else     state <= state_nxt;
      end

      always_comb begin
         state_nxt = state;
         cnt_nxt   = cnt;
         wrap_nxt  = 1'b0;
         load      = 1'b0;
         case (state)
            IDLE: begin
               load    = 1'b1;
               cnt_nxt = '0;
               if (en[i]) begin
                  state_nxt = RUN;
                  cnt_nxt   = start_cnt;
               end
            end
            RUN: begin
               if (!en[i]) begin
                  state_nxt = IDLE;
                  load      = 1'b1;
                  cnt_nxt   = '0;
               end else if (sync) begin
                  load    = 1'b1;
                  cnt_nxt = start_cnt;
               end else if (act_period == '0) begin
                  cnt_nxt = '0;
               end else if (cnt == act_period - CNT_W'(1)) begin
                  load     = 1'b1;
                  wrap_nxt = 1'b1;
                  cnt_nxt  = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end

`ifdef PWM_DEADTIME_EN
      logic [DT_W-1:0] pend_dead, act_dead, dcnt, dcnt_nxt;
      logic            lvl_q, hold;

      // Any level change restarts the blanking window, so short pulses are swallowed whole.
      always_comb begin
         dcnt_nxt = '0;
         hold     = 1'b0;
         if (active) begin
            if ((lvl != lvl_q) && (act_dead != '0)) begin
               hold     = 1'b1;
               dcnt_nxt = act_dead - DT_W'(1);
            end else if (dcnt != '0) begin
               hold     = 1'b1;
               dcnt_nxt = dcnt - DT_W'(1);
            end
         end
      end

      assign p_nxt = lvl && !hold;
      assign n_nxt = active && !lvl && !hold;

      always_ff @(posedge clk) begin
         if (rst) begin
            pend_dead <= '0;
            act_dead  <= '0;
            dcnt      <= '0;
            lvl_q     <= 1'b0;
         end else begin
            lvl_q <= lvl;
            dcnt  <= dcnt_nxt;
            if (load)   act_dead  <= pend_dead;
            if (wr_hit) pend_dead <= cfg.cfg_dead;
         end
      end
`else
      assign p_nxt = lvl;
      assign n_nxt = active && !lvl;
`endif

      always_ff @(posedge clk) begin
         if (rst) begin
            cnt         <= '0;
            pend_period <= '0;
            pend_high   <= '0;
            pend_phase  <= '0;
            act_period  <= '0;
            act_high    <= '0;
            p_q         <= 1'b0;
            n_q         <= 1'b0;
            wrap_q      <= 1'b0;
         end else begin
            cnt    <= cnt_nxt;
            p_q    <= p_nxt;
            n_q    <= n_nxt;
            wrap_q <= wrap_nxt;
            // Load sees the pending value from before this cycle's write.
            if (load) begin
               act_period <= pend_period;
               act_high   <= pend_high;
            end
            if (wr_hit) begin
               pend_period <= cfg.cfg_period;
               pend_high   <= cfg.cfg_high;
               pend_phase  <= cfg.cfg_phase;
            end
         end
      end

      assign out_p[i] = p_q;
      assign out_n[i] = n_q;
      assign wrap[i]  = wrap_q;
   end
endmodule

// File: tb/tb_pwm_multi_gen.sv
// Self-checking bench for pwm_multi_gen: directed scenarios plus random traffic, all checked
// against an elapsed-cycle arithmetic model of each channel.
module tb_pwm_multi_gen;
   localparam int N_CH  = 3;
   localparam int CNT_W = 16;
   localparam int DT_W  = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N_CH-1:0] en;
   logic            sync;
   logic [N_CH-1:0] out_p, out_n, wrap;

   pwm_multi_gen_if #(.N_CH(N_CH), .CNT_W(CNT_W), .DT_W(DT_W)) cfg_bus ();

   pwm_multi_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .DT_W(DT_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .sync  (sync),
      .cfg   (cfg_bus.slave),
      .out_p (out_p),
      .out_n (out_n),
      .wrap  (wrap)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int k        = 0;
   logic [N_CH-1:0] en_cur = '0;

   // Model: pending/active config, edge index of the last counter load, and the loaded value.
   int pp[N_CH], ph[N_CH], pph[N_CH], pd[N_CH];
   int ap[N_CH], ah[N_CH], ad[N_CH];
   int ld[N_CH], c0[N_CH];
   bit run[N_CH];

   task automatic chk(input string tag, input logic obs, input logic exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp_v);
      end
   endtask

   task automatic step(input logic rst_v, input logic [N_CH-1:0] en_v, input logic sync_v,
                       input logic we_v, input int ch_v, input int p_v, input int h_v,
                       input int ph_v, input int d_v);
      int   m;
      logic eo, eno, ew;
      rst                = rst_v;
      en                 = en_v;
      sync               = sync_v;
      cfg_bus.cfg_we     = we_v;
      cfg_bus.cfg_ch     = 2'(ch_v);
      cfg_bus.cfg_period = 16'(p_v);
      cfg_bus.cfg_high   = 16'(h_v);
      cfg_bus.cfg_phase  = 16'(ph_v);
`ifdef PWM_DEADTIME_EN
      cfg_bus.cfg_dead   = 8'(d_v);
`endif
      @(posedge clk);
      #1;
      k++;
      for (int i = 0; i < N_CH; i++) begin
         eo = 1'b0; eno = 1'b0; ew = 1'b0; m = -1;
         if (rst_v) begin
            pp[i] = 0; ph[i] = 0; pph[i] = 0; pd[i] = 0;
            ap[i] = 0; ah[i] = 0; ad[i] = 0; run[i] = 1'b0;
         end else if (!en_v[i]) begin
            ap[i] = pp[i]; ah[i] = ph[i]; ad[i] = pd[i]; run[i] = 1'b0;
         end else if (!run[i]) begin
            ap[i] = pp[i]; ah[i] = ph[i]; ad[i] = pd[i]; run[i] = 1'b1;
            ld[i] = k; c0[i] = (pph[i] < ap[i]) ? pph[i] : 0;
         end else begin
            if (ap[i] != 0) begin
               m  = (c0[i] + k - ld[i] - 1) % ap[i];
               ew = (m == ap[i] - 1) && !sync_v;
               if (ad[i] == 0) begin
                  eo  = (m < ah[i]);
                  eno = !eo;
               end else begin
                  // dead-time form, valid for 0 < high < period started at phase 0
                  eo  = (m >= ad[i]) && (m < ah[i]);
                  eno = (m >= ah[i] + ad[i]);
               end
            end
            if (sync_v) begin
               ap[i] = pp[i]; ah[i] = ph[i]; ad[i] = pd[i];
               ld[i] = k; c0[i] = (pph[i] < ap[i]) ? pph[i] : 0;
            end else if (ap[i] != 0 && m == ap[i] - 1) begin
               ap[i] = pp[i]; ah[i] = ph[i]; ad[i] = pd[i];
               ld[i] = k; c0[i] = 0;
            end
         end
         if (!rst_v && we_v && ch_v == i) begin
            pp[i] = p_v; ph[i] = h_v; pph[i] = ph_v; pd[i] = d_v;
         end
         chk($sformatf("k%0d ch%0d out_p", k, i), out_p[i], eo);
         chk($sformatf("k%0d ch%0d out_n", k, i), out_n[i], eno);
         chk($sformatf("k%0d ch%0d wrap", k, i), wrap[i], ew);
      end
   endtask

   task automatic run_n(input int n);
      for (int c = 0; c < n; c++) step(1'b0, en_cur, 1'b0, 1'b0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(input int ch, input int p, input int h, input int phs, input int d);
      step(1'b0, en_cur, 1'b0, 1'b1, ch, p, h, phs, d);
   endtask

   initial begin
      rst = 1'b1; en = '0; sync = 1'b0;
      cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_ch = '0;
      cfg_bus.cfg_period = '0; cfg_bus.cfg_high = '0; cfg_bus.cfg_phase = '0;
`ifdef PWM_DEADTIME_EN
      cfg_bus.cfg_dead = '0;
`endif
      // reset and idle
      for (int c = 0; c < 3; c++) step(1'b1, '0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      run_n(2);

      // basic 50% duty on ch0
      wr(0, 10, 5, 0, 0);
      run_n(1);
      en_cur = 3'b001;
      run_n(25);

      // shadow update: write high=2 while cnt=3
      en_cur = 3'b000; run_n(1);
      en_cur = 3'b001; run_n(4);
      wr(0, 10, 2, 0, 0);
      run_n(22);

      // two channels with phase offset, realigned by sync
      en_cur = 3'b000;
      wr(0, 8, 4, 0, 0);
      wr(1, 8, 4, 4, 0);
      run_n(1);
      en_cur = 3'b011; run_n(5);
      step(1'b0, en_cur, 1'b1, 1'b0, 0, 0, 0, 0, 0);
      run_n(20);

      // boundaries: period 0, high 0, high > period
      en_cur = 3'b000;
      wr(2, 0, 3, 0, 0);
      wr(0, 10, 0, 0, 0);
      wr(1, 10, 12, 0, 0);
      run_n(1);
      en_cur = 3'b111; run_n(25);

      // period 1, then a write to a non-existent channel must change nothing
      en_cur = 3'b000;
      wr(2, 1, 1, 0, 0);
      run_n(1);
      en_cur = 3'b100; run_n(6);
      wr(3, 5, 2, 3, 0);
      run_n(3);
      en_cur = 3'b000; run_n(1);
      en_cur = 3'b100; run_n(6);

      // reset while enabled clears all configuration
      en_cur = 3'b111;
      step(1'b1, en_cur, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      run_n(5);

      // random traffic: writes while running, enable toggles, sync pulses
      for (int it = 0; it < 60; it++) begin
         int r, nc;
         r = $urandom_range(0, 9);
         if (r < 4)
            wr($urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 14),
               $urandom_range(0, 14), 0);
         else if (r < 6)
            en_cur = 3'($urandom_range(0, 7));
         nc = $urandom_range(1, 12);
         for (int c = 0; c < nc; c++)
            step(1'b0, en_cur, ($urandom_range(0, 7) == 0), 1'b0, 0, 0, 0, 0, 0);
      end

`ifdef PWM_DEADTIME_EN
      en_cur = 3'b000;
      wr(0, 10, 5, 0, 2);
      wr(1, 0, 0, 0, 0);
      wr(2, 0, 0, 0, 0);
      run_n(1);
      en_cur = 3'b001; run_n(30);
      en_cur = 3'b000;
      wr(0, 10, 5, 0, 0);
      run_n(1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/pwm_multi_gen.md
Name: pwm_multi_gen

Overview:
- Multi-channel, runtime-programmable PWM stimulus generator, integer emulator-cycle time base.
- Generalises the fixed single-channel 50%-duty square-wave source used to drive filter models such as the RLC testbench.
- Each channel has its own period, high time and phase, with glitch-free shadow updates.
- Produces complementary outputs that can drive msdsl ITE-style real-valued switches.

Parameters:
- N_CH, 2, number of independent PWM channels (1..16).
- CNT_W, 16, width of the period, high-time, phase and counter fields.
- DT_W, 8, width of the dead-time field (used only with the optional feature).

Ports:
- clk  in  1  emulator clock.
- rst  in  1  synchronous, active-high reset.
- en  in  N_CH  per-channel run enable.
- sync  in  1  single-cycle pulse; realigns all enabled channels to their phase.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  $clog2(N_CH) (min 1)  target channel of the write.
- cfg_period  in  CNT_W  period in clk cycles.
- cfg_high  in  CNT_W  high time in clk cycles.
- cfg_phase  in  CNT_W  counter start value on sync or enable.
- cfg_dead  in  DT_W  dead-time cycles; present only with PWM_DEADTIME_EN.
- out_p  out  N_CH  registered PWM output.
- out_n  out  N_CH  registered complementary output.
- wrap  out  N_CH  one-cycle pulse when a channel's counter restarts from period-1.

Behaviour:
- Reset: all counters, pending and active config registers, out_p, out_n and wrap are 0.
- Config write:
  - cfg_we loads pending[cfg_ch] in the same cycle.
  - cfg_ch >= N_CH: the write is ignored.
- Active config loads from pending at these points only:
  - counter wrap;
  - while en[i]=0;
  - on a sync cycle.
  - Consequence: a mid-period write never truncates the current period.
- Per-channel state: IDLE, RUN.
- IDLE (en[i]=0):
  - cnt=0; out_p=out_n=0; wrap=0.
  - Active config tracks pending every cycle.
- IDLE->RUN: on the first cycle en[i]=1.
  - Counter loads phase if phase<period, else 0.
- RUN:
  - cnt increments by 1.
  - At cnt==period-1: cnt becomes 0, wrap pulses the next cycle, and the shadow load happens.
- RUN->IDLE: when en[i] falls; takes effect the next cycle.
- sync in RUN:
  - Shadow load happens, then the counter loads the new phase (0 if phase >= period).
  - No wrap pulse.
  - sync takes priority over a wrap in the same cycle.
- Raw level: raw = (cnt < high).
  - out_p = raw, registered: one-cycle latency from cnt.
- Boundaries:
  - period==0: cnt held at 0; out_p=0; out_n=0; wrap never asserts.
  - high==0: out_p constant 0.
  - high>=period (period>0): out_p constant 1.
  - period==1: wrap pulses every cycle.
- out_n in RUN, without dead time: ~out_p, same register stage.
- Counter arithmetic is unsigned CNT_W; no saturation is needed because cnt < period always holds.
- Simultaneous cfg_we and shadow load on the same channel: the new pending value is not yet visible; it loads at the next load point.

Optional Feature:
- Macro: PWM_DEADTIME_EN.
- Defined:
  - cfg_dead port exists; pending/active dead registers exist.
  - After every raw edge, both out_p and out_n stay 0 for dead cycles, then the new level asserts.
  - dead==0 behaves exactly as the undefined case.
  - If dead >= the pulse width, the affected output never asserts during that pulse.
- Undefined: no cfg_dead port and no dead-time logic; out_n = ~out_p in RUN.

Test Plan:
- Reset and idle: assert rst 3 cycles, en=0 -> out_p=out_n=wrap=0 at every sampled cycle.
- Basic duty: ch0 period=10, high=5, phase=0, en[0]=1 -> out_p 5 high / 5 low repeating; first high appears one cycle after en; wrap every 10 cycles.
- Shadow update: while running period=10, write high=2 at cnt=3 -> current period keeps 5 high; the next period shows 2 high.
- Phase and sync, two channels:
  - Setup: both period=8, high=4; ch1 phase=4; pulse sync.
  - Response: out_p[1] is out_p[0] delayed by 4 cycles; no wrap on the sync cycle.
- Boundaries:
  - period=0 -> outputs 0 and no wrap.
  - high=0 -> out_p=0.
  - high=12 with period=10 -> out_p=1.
  - period=1 -> wrap every cycle.
  - cfg_ch=N_CH -> no config change.
- Dead time (PWM_DEADTIME_EN): period=10, high=5, dead=2 -> out_p high 3 cycles, out_n high 3 cycles, both low 2 cycles after each edge; never both high.
